// File: rtl/mem_reader_fifo.sv
// Circular-buffer FIFO holding {addr, data} read responses.
// A push while full is accepted only when it coincides with a pop.
module mem_reader_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pipelined_memory_reader.sv
// Issues reads to a fixed-latency memory, tracks them in a valid/address shift pipeline
// and buffers returned {addr, data} in a FIFO behind a valid/ready response port.
module pipelined_memory_reader #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [ADDR_W-1:0]          s_addr,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_data,
    output logic                       mem_enable,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     accept, pop, push;
    logic [CNT_W-1:0]         occ_q, occ_d;
    logic [READ_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0]        pipe_addr_q [READ_LATENCY];
    logic [ADDR_W-1:0]        pipe_addr_d [READ_LATENCY];
    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    logic                     fifo_full, fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     unused_fifo_status;

    // Occupancy counts in-flight plus buffered reads, so a FIFO slot always exists on return.
    assign s_ready    = (occ_q < CNT_W'(DEPTH));
    assign accept     = s_valid && s_ready;
    assign mem_enable = accept;
    assign mem_addr   = s_addr;
    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign push       = pipe_vld_q[READ_LATENCY-1];
    assign m_addr     = fifo_rdata[DATA_W +: ADDR_W];
    assign m_data     = fifo_rdata[DATA_W-1:0];
    assign occupancy  = occ_q;

    assign unused_fifo_status = fifo_full ^ (^fifo_count);

    always_comb begin
        pipe_vld_d[0]  = accept;
        pipe_addr_d[0] = s_addr;
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_addr_d[k] = pipe_addr_q[k-1];
        end
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            occ_q      <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            occ_q      <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        pipe_addr_q <= pipe_addr_d;
    end

    // The last pipeline stage lines up with mem_data; capture both on the same edge.
    mem_reader_fifo #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata({pipe_addr_q[READ_LATENCY-1], mem_data}),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule
